// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the fetch PC, keeps one instruction-memory request outstanding,
// holds a response across a stall and discards responses made stale by a redirect.
// Optional feature macro: FETCH_STATS_EN adds fetch/stall counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic        pc_write_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] Ins_out,
    output logic [31:0] PC_out,
`ifdef FETCH_STATS_EN
    output logic [31:0] fetch_count_out,
    output logic [31:0] stall_count_out,
`endif
    output logic        valid_out
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] buf_ins, buf_ins_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;
    logic [31:0] redir_tgt;

    // Targets are word aligned; the low two bits of the request are ignored.
    assign redir_tgt = redirect_pc_in & ~32'h3;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            buf_ins  <= 32'h0;
            redir_pc <= 32'h0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            buf_ins  <= buf_ins_nxt;
            redir_pc <= redir_pc_nxt;
        end
    end

    // Next-state and output decode; redirect always wins over pc_write_in.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        buf_ins_nxt   = buf_ins;
        redir_pc_nxt  = redir_pc;
        imem_req_out  = 1'b0;
        imem_addr_out = fetch_pc;
        Ins_out       = NOP_INS;
        valid_out     = 1'b0;
        PC_out        = fetch_pc + 32'd4;
        case (state)
            FETCH: begin
                imem_req_out = 1'b1;
                if (imem_ready_in) begin
                    Ins_out   = imem_data_in;
                    valid_out = 1'b1;
                end
                if (redirect_in && imem_ready_in) begin
                    fetch_pc_nxt = redir_tgt;
                end else if (redirect_in) begin
                    redir_pc_nxt = redir_tgt;
                    state_nxt    = DROP;
                end else if (imem_ready_in && pc_write_in) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                end else if (imem_ready_in) begin
                    buf_ins_nxt = imem_data_in;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                Ins_out   = buf_ins;
                valid_out = 1'b1;
                if (redirect_in) begin
                    fetch_pc_nxt = redir_tgt;
                    state_nxt    = FETCH;
                end else if (pc_write_in) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = FETCH;
                end
            end
            DROP: begin
                // Stale address stays on the bus until the old request completes.
                imem_req_out = 1'b1;
                PC_out       = redir_pc + 32'd4;
                if (redirect_in) redir_pc_nxt = redir_tgt;
                if (imem_ready_in) begin
                    fetch_pc_nxt = redirect_in ? redir_tgt : redir_pc;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        // Reset abandons any request immediately and parks the outputs.
        if (reset_in) begin
            imem_req_out  = 1'b0;
            valid_out     = 1'b0;
            Ins_out       = NOP_INS;
            PC_out        = RESET_PC + 32'd4;
            imem_addr_out = RESET_PC;
        end
    end

`ifdef FETCH_STATS_EN
    // Delivered-instruction and memory-wait counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            fetch_count_out <= 32'h0;
            stall_count_out <= 32'h0;
        end else begin
            if (valid_out && pc_write_in && !redirect_in)
                fetch_count_out <= fetch_count_out + 32'd1;
            if (imem_req_out && !imem_ready_in)
                stall_count_out <= stall_count_out + 32'd1;
        end
    end
`endif

endmodule
